// File: rtl/apb_cmd_master_if.sv
// Command/response handshakes plus APB master signals for apb_cmd_master.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; APB stalls through apb_pready.
// Ports: master = block side (drives cmd_ready, rsp_*, apb_* requests); slave = the mirror (sequencer + APB target).
interface apb_cmd_master_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    logic          apb_psel;
    logic          apb_penable;
    logic [AW-1:0] apb_paddr;
    logic          apb_pwrite;
    logic [31:0]   apb_pwdata;
    logic [31:0]   apb_prdata;
    logic          apb_pready;
    logic          apb_pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output apb_psel, apb_penable, apb_paddr, apb_pwrite, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  apb_psel, apb_penable, apb_paddr, apb_pwrite, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Buffers {write, addr, wdata} commands and replays them in order as APB2/APB3 transfers, one outstanding at a time.
// Latency: pop->psel 1 cycle; each transfer is SETUP + ACCESS(>=1, pready-driven or TIMEOUT abort) + RESP, 3 cycles minimum.
// Backpressure: cmd_ready low while the FIFO is full; RESP holds until rsp_ready, which stalls the next transfer.
// Ports: clk, rstn (async active-low); bus = command/response handshakes and APB master pins; busy = work pending.
module apb_cmd_master #(
    parameter int AW      = 32,
    parameter int CDEPTH  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    apb_cmd_master_if.master bus,
    output logic             busy
);
    localparam int PW = $clog2(CDEPTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort is taken on the edge that closes the TIMEOUT-th stalled ACCESS cycle.
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(CDEPTH);

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    cmd_t          mem [CDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    cmd_t          head;

    state_t        state_q, state_d;
    logic          psel_q, psel_d, penable_q, penable_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d, tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // ---------------- command FIFO ----------------
    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign bus.cmd_ready = rstn & ~full;
    assign push          = bus.cmd_valid & bus.cmd_ready;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // ---------------- transfer FSM ----------------
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready has priority over a timeout landing on the same edge.
                if (bus.apb_pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = pwrite_q ? 32'h0 : bus.apb_prdata;
                    err_d     = bus.apb_pslverr;
                    tmo_d     = 1'b0;
                    state_d   = RESP;
                end else if (TIMEOUT > 0 && cnt_q == TMO_LAST) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = 32'h0;
                    err_d     = 1'b1;
                    tmo_d     = 1'b1;
                    state_d   = RESP;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                // Chain straight into SETUP so back-to-back transfers cost 3 cycles.
                if (bus.rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = head.addr;
            pwrite_d  = head.write;
            pwdata_d  = head.wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;
    assign busy            = !empty || (state_q != IDLE);
endmodule
